// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-access stage: access sizes,
// legal size sets and load-result extraction.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  // Bit n set means funct3 value n is legal for that access type.
  localparam logic [7:0] LOAD_SIZE_OK  = 8'b0011_0111;
  localparam logic [7:0] STORE_SIZE_OK = 8'b0000_0111;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  offset,
                                               input logic [2:0]  size);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_B:   load_extract = {{24{b[7]}}, b};
      MEM_BU:  load_extract = {24'h0, b};
      MEM_H:   load_extract = {{16{h[15]}}, h};
      MEM_HU:  load_extract = {16'h0, h};
      default: load_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_dmem_bram.sv
// Single-port word-organised data memory: byte-enable write, registered read
// that holds when no read is requested.
module dmem_bram #(
  parameter int unsigned DEPTH     = 1024,
  parameter string       INIT_FILE = "",
  parameter int unsigned AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we && be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: alignment/legality checks, store lane steering,
// synchronous data memory and a one-cycle registered write-back result.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DMEM_DEPTH     = 1024,
  parameter string       DMEM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic        stall,
  input  logic [31:0] alu_data,
  input  logic [31:0] memory_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_size,
  input  logic        reg_write_in,
  input  logic [4:0]  rd_id_in,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd_id,
  output logic [31:0] wb_data,
  output logic [31:0] mem_fwd_data,
  output logic        access_fault,
  output logic [31:0] fault_addr
);

  localparam int unsigned AW = $clog2(DMEM_DEPTH);

  logic        active, size_ok, misalign, fault, do_write, do_read, is_half;
  logic [3:0]  be;
  logic [31:0] wdata, raw_word;
  logic [1:0]  off_q;
  logic [2:0]  size_q;
  logic        is_load_q;

  assign active   = in_valid && !stall && (mem_read || mem_write);
  assign is_half  = (mem_size == MEM_H) || (mem_size == MEM_HU);
  assign size_ok  = mem_read ? LOAD_SIZE_OK[mem_size] : STORE_SIZE_OK[mem_size];
  assign misalign = (is_half && alu_data[0]) ||
                    ((mem_size == MEM_W) && (alu_data[1:0] != 2'b00));
  assign fault    = active && ((mem_read && mem_write) || !size_ok || misalign);
  assign do_write = active && mem_write && !fault;
  assign do_read  = active && mem_read && !fault;

  always_comb begin
    be    = 4'b1111;
    wdata = memory_data;
    case (mem_size[1:0])
      2'b00: begin
        be    = 4'b0001 << alu_data[1:0];
        wdata = {4{memory_data[7:0]}};
      end
      2'b01: begin
        be    = alu_data[1] ? 4'b1100 : 4'b0011;
        wdata = {2{memory_data[15:0]}};
      end
      default: ;
    endcase
  end

  dmem_bram #(
    .DEPTH     (DMEM_DEPTH),
    .INIT_FILE (DMEM_INIT_FILE)
  ) u_dmem (
    .clk   (clk),
    .we    (do_write),
    .be    (be),
    .re    (do_read),
    .addr  (alu_data[AW+1:2]),
    .wdata (wdata),
    .rdata (raw_word)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd_id     <= '0;
      mem_fwd_data <= '0;
      access_fault <= 1'b0;
      fault_addr   <= '0;
      off_q        <= '0;
      size_q       <= '0;
      is_load_q    <= 1'b0;
    end else if (stall) begin
      access_fault <= 1'b0;
    end else begin
      wb_valid     <= in_valid;
      wb_reg_write <= in_valid && reg_write_in && (rd_id_in != 5'd0) && !fault;
      wb_rd_id     <= rd_id_in;
      mem_fwd_data <= alu_data;
      access_fault <= fault;
      if (fault) fault_addr <= alu_data;
      off_q        <= alu_data[1:0];
      size_q       <= mem_size;
      is_load_q    <= do_read;
    end
  end

  // Non-load results reuse the forwarding register as the pass-through value.
  assign wb_data = is_load_q ? load_extract(raw_word, off_q, size_q) : mem_fwd_data;

endmodule
